// File: rtl/riscv_pkg.sv
// Shared core types: boot loader FSM encoding and header width.
package riscv_pkg;

    localparam int LOADER_LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input link and instruction-memory write port of the boot loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // master: stream source and memory sink; slave: the loader itself
    modport master (output in_valid, in_data,
                    input  in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input  in_valid, in_data,
                    output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word and flags the 4th byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_done
);
    logic [23:0] sh;
    logic [1:0]  lane;

    // The 4th byte goes straight into bits [31:24] so the word is ready on the accepting edge.
    assign word      = {din, sh};
    assign word_done = en && (lane == 2'd3);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            lane <= '0;
        end else if (clr) begin
            sh   <= '0;
            lane <= '0;
        end else if (en) begin
            sh   <= {din, sh[23:8]};
            lane <= lane + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length-prefixed byte stream -> imem words, holds the core in reset until loaded.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = LOADER_LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    input  logic          load_req,
    output logic          core_rst,
    output logic          done,
    output logic          err
);
    localparam int               DEPTH   = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_LEN0 = LEN0;
    localparam logic [2:0] ST_LEN1 = LEN1;
    localparam logic [2:0] ST_DATA = DATA;
    localparam logic [2:0] ST_DONE = DONE;
    localparam logic [2:0] ST_ERR  = ERR;

    logic [2:0]       state, ns;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] n_hdr;
    logic [ADDR_W:0]  n_words;
    logic [ADDR_W:0]  word_idx;
    logic             flush;
    logic             accept, clr, asm_en, word_done, word_last;
    logic [31:0]      word;

    assign accept    = bus.in_valid && bus.in_ready;
    assign n_hdr     = {bus.in_data, len_lo};
    assign asm_en    = accept && (state == ST_DATA);
    assign clr       = (ns == ST_LEN0) && (state != ST_LEN0);
    assign word_last = word_done && (word_idx == n_words - 1'b1);

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (asm_en),
        .din       (bus.in_data),
        .word      (word),
        .word_done (word_done)
    );

    // NOTE: next-state is assigned a default first so no path through the case infers a latch.
    always_comb begin
        ns = state;
        case (state)
            ST_IDLE: ns = ST_LEN0;
            ST_LEN0: if (accept) ns = ST_LEN1;
            ST_LEN1: if (accept) begin
                if (n_hdr == '0)         ns = ST_DONE;
                else if (n_hdr > DEPTH_L) ns = ST_ERR;
                else                      ns = ST_DATA;
            end
            // flush marks the cycle the last word is on the write port; DONE follows it
            ST_DATA: if (flush) ns = ST_DONE;
            ST_DONE, ST_ERR: if (load_req) ns = ST_LEN0;
            default: ns = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            len_lo         <= '0;
            n_words        <= '0;
            word_idx       <= '0;
            flush          <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_rst       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state       <= ns;
            flush       <= word_last;
            bus.imem_we <= word_done;
            if (state == ST_LEN0 && accept) len_lo  <= bus.in_data;
            if (state == ST_LEN1 && accept) n_words <= n_hdr[ADDR_W:0];
            if (word_done) begin
                bus.imem_addr  <= word_idx[ADDR_W-1:0];
                bus.imem_wdata <= word;
                word_idx       <= word_idx + 1'b1;
            end
            if (clr) word_idx <= '0;
            // the final byte of the program closes the link before DONE is reached
            bus.in_ready <= (ns == ST_LEN0 || ns == ST_LEN1 || ns == ST_DATA) && !word_last;
            core_rst     <= (ns != ST_DONE);
            done         <= (ns == ST_DONE);
            err          <= (ns == ST_ERR);
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of `datapath`. It receives a length-prefixed byte stream over a valid/ready link and assembles little-endian 32-bit words. It writes those words into instruction memory from word address 0, and holds the core in reset (`core_rst`) until the whole program has been written. This replaces hand-placed instructions in the simulation bench with a real load path.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width. Depth `DEPTH = 2**ADDR_W` words.
- `LEN_W`, 16: width of the word-count header. Fixed at 16; kept as a parameter only for the package constant.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `load_req`  in  1  single-cycle pulse; restarts loading from DONE or ERR.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  word to write.
- `core_rst`  out  1  reset to `datapath`; high while loading or on error.
- `done`  out  1  program fully loaded.
- `err`  out  1  header word count exceeded DEPTH.

## Operation
- Stream format: 2 header bytes giving word count N (LSB first), followed by 4·N data bytes. Each word is little-endian: first byte → bits [7:0].
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- FSM states and transitions:
  - IDLE: reset state → LEN0 unconditionally.
  - LEN0: accept the low count byte → LEN1.
  - LEN1: accept the high count byte, then branch:
    - N = 0 → DONE.
    - N > DEPTH → ERR.
    - otherwise → DATA.
  - DATA: accept bytes. After the 4th byte of a word, issue the write. After word N−1 is written → DONE.
  - DONE: wait; `load_req` → LEN0.
  - ERR: wait; `load_req` → LEN0.
- `load_req` is ignored in IDLE, LEN0, LEN1 and DATA.
- `in_ready` = 1 in LEN0, LEN1 and DATA; 0 in IDLE, DONE and ERR. Bytes offered in DONE or ERR are not consumed.
- Word index counter is ADDR_W+1 bits wide and resets to 0 on entry to LEN0. `imem_addr` is the counter's low ADDR_W bits. Word N = DEPTH is legal and writes address DEPTH−1 last, with no wrap.
- Byte lane counter is 2 bits and wraps 3→0 on each completed word. It is cleared on entry to LEN0.
- `core_rst` = 1 in every state except DONE. `done` = 1 only in DONE. `err` = 1 only in ERR.
- Reset mid-load: everything returns to IDLE. Partial words are discarded. Already-written memory is not cleared.

## Timing
- All outputs are registered.
- Reset values:
  - `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `core_rst` = 1, `done` = 0, `err` = 0.
- `in_ready` first rises on the first clock edge after `rst` deasserts (IDLE→LEN0).
- Write latency: `imem_we` pulses high for exactly one cycle, on the cycle after the edge that accepts a word's 4th byte. `imem_addr` and `imem_wdata` are valid in that same cycle.
- The link sustains one byte per cycle with no bubbles between words.
- `core_rst` falls and `done` rises on the cycle after the last write (or on the cycle after the header when N = 0).
- `in_valid` gaps of any length simply stall the FSM.

## Structure
- Add to shared `riscv_pkg`:
  - `loader_state_t` enum: IDLE, LEN0, LEN1, DATA, DONE, ERR.
  - `LOADER_LEN_W = 16`.
- One natural sub-module, `word_assembler`: shifts bytes into a 32-bit register, tracks the 2-bit lane counter, and flags word-complete. It has a synchronous clear input driven on entry to LEN0.

## Test plan
- Reset release with N=2, bytes 02 00 13 05 A0 00 93 05 B0 00 streamed back-to-back:
  - two `imem_we` pulses: addr 0 = 0x00A00513, addr 1 = 0x00B00593.
  - `core_rst` falls one cycle after the second pulse.
- Same stream with `in_valid` dropped for 3 cycles mid-word → identical writes; `in_ready` stays 1 throughout.
- Header 00 00 → no writes; `done` = 1 and `core_rst` = 0 on the cycle after the second header byte.
- ADDR_W=8, header 01 01 (N=257) → ERR, `err` = 1, `in_ready` = 0, `core_rst` held 1. Then `load_req` → `in_ready` = 1, `err` = 0.
- `rst` pulsed after 6 data bytes of an N=2 load:
  - outputs return to their reset values.
  - a reload of the N=2 stream writes addr 0 and addr 1 correctly.
- N=256 (DEPTH) full load → last write to addr 0xFF, then DONE, with no write to addr 0 after the first.
